// File: rtl/doce_tl_pkg.sv
// Shared DoCE transport-layer definitions: one-beat header layout, AXIS widths
// and the depacketiser state encoding. The transmit packetizer uses the same package.
package doce_tl_pkg;

  localparam int unsigned AXIS_DATA_W = 128;
  localparam int unsigned AXIS_KEEP_W = 16;
  localparam int unsigned KEEP_CNT_W  = $clog2(AXIS_KEEP_W + 1);

  localparam int unsigned DST_LSB = 0;
  localparam int unsigned OPC_LSB = 8;
  localparam int unsigned OPC_W   = 8;
  localparam int unsigned LEN_LSB = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } rx_state_e;

  function automatic logic [KEEP_CNT_W-1:0] keep_popcount(input logic [AXIS_KEEP_W-1:0] keep);
    logic [KEEP_CNT_W-1:0] cnt;
    cnt = '0;
    for (int unsigned i = 0; i < AXIS_KEEP_W; i++) begin
      cnt = cnt + KEEP_CNT_W'(keep[i]);
    end
    return cnt;
  endfunction

endpackage

// File: rtl/rx_depacketing_axis_out_reg.sv
// Single-entry registered AXI-Stream stage; upstream ready passes through
// from the sink whenever the entry is occupied.
module axis_out_reg #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned KEEP_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic [KEEP_W-1:0] s_keep,
  input  logic              s_last,
  input  logic              m_ready,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data,
  output logic [KEEP_W-1:0] m_keep,
  output logic              m_last
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [KEEP_W-1:0] keep_q, keep_d;
  logic              last_q, last_d;
  logic              load;

  always_comb begin
    s_ready = !valid_q || m_ready;
    load    = s_valid && s_ready;
    valid_d = valid_q;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = s_data;
      keep_d  = s_keep;
      last_d  = s_last;
    end else if (m_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      keep_q  <= keep_d;
      last_q  <= last_d;
    end
  end

  assign m_valid = valid_q;
  assign m_data  = data_q;
  assign m_keep  = keep_q;
  assign m_last  = last_q;

endmodule

// File: rtl/rx_depacketing.sv
// DoCE receive depacketiser: strips the one-beat header, drops foreign packets,
// forwards payload through axis_out_reg and flags length mismatches.
// Define RX_DROP_CNT_EN to add the io_drop_cnt dropped-packet counter.
module rx_depacketing
  import doce_tl_pkg::*;
#(
  parameter int unsigned NODE_ID_W = 8,
  parameter int unsigned LEN_W     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NODE_ID_W-1:0]   io_node_id,
  output logic                   io_axi_str_from_router_ready,
  input  logic                   io_axi_str_from_router_valid,
  input  logic [AXIS_DATA_W-1:0] io_axi_str_from_router_bits_tdata,
  input  logic [AXIS_KEEP_W-1:0] io_axi_str_from_router_bits_tkeep,
  input  logic                   io_axi_str_from_router_bits_tlast,
  input  logic                   io_axis_wr_to_fsm_ready,
  output logic                   io_axis_wr_to_fsm_valid,
  output logic [AXIS_DATA_W-1:0] io_axis_wr_to_fsm_bits_tdata,
  output logic [AXIS_KEEP_W-1:0] io_axis_wr_to_fsm_bits_tkeep,
  output logic                   io_axis_wr_to_fsm_bits_tlast,
  output logic [OPC_W-1:0]       io_rx_opcode,
  output logic                   io_len_err
`ifdef RX_DROP_CNT_EN
  ,
  output logic [31:0]            io_drop_cnt
`endif
);

  rx_state_e            state_q, state_d;
  logic [OPC_W-1:0]     opcode_q, opcode_d;
  logic [LEN_W-1:0]     len_q, len_d;
  logic [LEN_W-1:0]     cnt_q, cnt_d;
  logic                 len_err_q, len_err_d;
`ifdef RX_DROP_CNT_EN
  logic [31:0]          drop_cnt_q, drop_cnt_d;
`endif

  logic                 in_ready;
  logic                 in_hs;
  logic                 out_s_valid;
  logic                 out_s_ready;
  logic [NODE_ID_W-1:0] hdr_dst;
  logic [OPC_W-1:0]     hdr_opc;
  logic [LEN_W-1:0]     hdr_len;
  logic [LEN_W:0]       cnt_sum;

  assign hdr_dst = io_axi_str_from_router_bits_tdata[DST_LSB +: NODE_ID_W];
  assign hdr_opc = io_axi_str_from_router_bits_tdata[OPC_LSB +: OPC_W];
  assign hdr_len = io_axi_str_from_router_bits_tdata[LEN_LSB +: LEN_W];

  // Ready is forced low while reset is held so every output reads 0 in reset.
  always_comb begin
    unique case (state_q)
      PASS:    in_ready = out_s_ready;
      default: in_ready = 1'b1;
    endcase
    in_ready    = in_ready && reset;
    in_hs       = io_axi_str_from_router_valid && in_ready;
    out_s_valid = io_axi_str_from_router_valid && (state_q == PASS);
    cnt_sum     = {1'b0, cnt_q}
                + (LEN_W+1)'(keep_popcount(io_axi_str_from_router_bits_tkeep));
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    len_err_d = 1'b0;
`ifdef RX_DROP_CNT_EN
    drop_cnt_d = drop_cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_hs) begin
          if (io_axi_str_from_router_bits_tlast) begin
`ifdef RX_DROP_CNT_EN
            drop_cnt_d = drop_cnt_q + 32'd1;
`endif
          end else if (hdr_dst != io_node_id) begin
            state_d = DROP;
`ifdef RX_DROP_CNT_EN
            drop_cnt_d = drop_cnt_q + 32'd1;
`endif
          end else begin
            opcode_d = hdr_opc;
            len_d    = hdr_len;
            cnt_d    = '0;
            state_d  = PASS;
          end
        end
      end
      PASS: begin
        if (in_hs) begin
          cnt_d = cnt_sum[LEN_W] ? '1 : cnt_sum[LEN_W-1:0];
          if (io_axi_str_from_router_bits_tlast) begin
            len_err_d = (cnt_d != len_q);
            state_d   = IDLE;
          end
        end
      end
      DROP: begin
        if (in_hs && io_axi_str_from_router_bits_tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      opcode_q  <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      len_err_q <= 1'b0;
`ifdef RX_DROP_CNT_EN
      drop_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      len_err_q <= len_err_d;
`ifdef RX_DROP_CNT_EN
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  axis_out_reg #(
    .DATA_W (AXIS_DATA_W),
    .KEEP_W (AXIS_KEEP_W)
  ) u_out_reg (
    .clk     (clock),
    .rst_n   (reset),
    .s_valid (out_s_valid),
    .s_ready (out_s_ready),
    .s_data  (io_axi_str_from_router_bits_tdata),
    .s_keep  (io_axi_str_from_router_bits_tkeep),
    .s_last  (io_axi_str_from_router_bits_tlast),
    .m_ready (io_axis_wr_to_fsm_ready),
    .m_valid (io_axis_wr_to_fsm_valid),
    .m_data  (io_axis_wr_to_fsm_bits_tdata),
    .m_keep  (io_axis_wr_to_fsm_bits_tkeep),
    .m_last  (io_axis_wr_to_fsm_bits_tlast)
  );

  assign io_axi_str_from_router_ready = in_ready;
  assign io_rx_opcode                 = opcode_q;
  assign io_len_err                   = len_err_q;
`ifdef RX_DROP_CNT_EN
  assign io_drop_cnt                  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_rx_depacketing.sv
// Directed self-checking bench for rx_depacketing (optionally with RX_DROP_CNT_EN).
module tb_rx_depacketing;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   node_id = 8'h05;
  logic         in_ready;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic [15:0]  in_keep = '0;
  logic         in_last = 1'b0;
  logic         sink_ready = 1'b1;
  logic         out_valid;
  logic [127:0] out_data;
  logic [15:0]  out_keep;
  logic         out_last;
  logic [7:0]   rx_opcode;
  logic         len_err;
`ifdef RX_DROP_CNT_EN
  logic [31:0]  drop_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [127:0] d;
    logic [15:0]  k;
    logic         l;
  } beat_t;

  beat_t cap[$];
  int    len_err_cnt = 0;
  int    len_err_on_last = 0;
  logic  prev_stall = 1'b0;
  beat_t prev_beat;
  logic  bp_en = 1'b0;
  logic [3:0] bp_pat = 4'b1001;
  int    bp_idx = 0;

  rx_depacketing dut (
    .clock                             (clock),
    .reset                             (reset),
    .io_node_id                        (node_id),
    .io_axi_str_from_router_ready      (in_ready),
    .io_axi_str_from_router_valid      (in_valid),
    .io_axi_str_from_router_bits_tdata (in_data),
    .io_axi_str_from_router_bits_tkeep (in_keep),
    .io_axi_str_from_router_bits_tlast (in_last),
    .io_axis_wr_to_fsm_ready           (sink_ready),
    .io_axis_wr_to_fsm_valid           (out_valid),
    .io_axis_wr_to_fsm_bits_tdata      (out_data),
    .io_axis_wr_to_fsm_bits_tkeep      (out_keep),
    .io_axis_wr_to_fsm_bits_tlast      (out_last),
    .io_rx_opcode                      (rx_opcode),
    .io_len_err                        (len_err)
`ifdef RX_DROP_CNT_EN
    ,
    .io_drop_cnt                       (drop_cnt)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sink ready follows bp_pat (bit 3 first: 1,0,0,1) while bp_en, else stays high.
  always @(posedge clock) begin
    #2;
    if (bp_en) begin
      sink_ready = bp_pat[3 - bp_idx];
      bp_idx     = (bp_idx + 1) % 4;
    end else begin
      sink_ready = 1'b1;
    end
  end

  // Output monitor: records transferred beats, length-error pulses and stall stability.
  always @(negedge clock) begin
    if (reset) begin
      if (prev_stall) begin
        chk("hold_valid", {127'b0, out_valid}, 128'd1);
        chk("hold_beat", {out_data, out_keep, out_last}, prev_beat);
      end
      prev_stall = out_valid && !sink_ready;
      prev_beat  = '{d: out_data, k: out_keep, l: out_last};
      if (out_valid && sink_ready) cap.push_back('{d: out_data, k: out_keep, l: out_last});
      if (len_err) begin
        len_err_cnt++;
        if (out_valid && out_last) len_err_on_last++;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  function automatic logic [127:0] hdr(input logic [7:0] dst, input logic [7:0] opc,
                                       input logic [15:0] len);
    return {96'hFEED_0000_0000_0000_0000_BEEF, len, opc, dst};
  endfunction

  // Called at posedge+2; returns at posedge+2 after the beat is accepted, valid left high.
  task automatic send(input logic [127:0] d, input logic [15:0] k, input logic l,
                      output int waits);
    bit done;
    in_valid = 1'b1;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    waits    = 0;
    done     = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (in_ready) begin
        @(posedge clock);
        #2;
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    if (!done) chk("send_timeout", 128'd0, 128'd1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clock);
    #2;
  endtask

  task automatic chk_beat(input string tag, input int idx, input logic [127:0] d,
                          input logic [15:0] k, input logic l);
    if (idx < cap.size()) begin
      chk({tag, "_data"}, cap[idx].d, d);
      chk({tag, "_keep"}, {112'b0, cap[idx].k}, {112'b0, k});
      chk({tag, "_last"}, {127'b0, cap[idx].l}, {127'b0, l});
    end else begin
      chk({tag, "_missing"}, 128'd0, 128'd1);
    end
  endtask

  localparam logic [127:0] D1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
  localparam logic [127:0] D2 = 128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0;
  localparam logic [127:0] D3 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
  localparam logic [127:0] D4 = 128'hCAFE_BABE_DEAD_BEEF_0BAD_F00D_1234_5678;

  initial begin
    int w;
    // Reset state
    repeat (2) @(posedge clock);
    #2;
    chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst_out_keep_last", {111'b0, out_keep, out_last}, 128'd0);
    chk("rst_opcode_err", {119'b0, rx_opcode, len_err}, 128'd0);
    chk("rst_in_ready", {127'b0, in_ready}, 128'd0);
`ifdef RX_DROP_CNT_EN
    chk("rst_drop_cnt", {96'b0, drop_cnt}, 128'd0);
`endif
    reset = 1'b1;
    idle(1);
    chk("idle_in_ready", {127'b0, in_ready}, 128'd1);

    // Matching packet: len 40 = 16+16+8
    cap.delete(); len_err_cnt = 0; len_err_on_last = 0;
    send(hdr(8'h05, 8'h21, 16'd40), 16'hFFFF, 1'b0, w);
    send(D1, 16'hFFFF, 1'b0, w);
    send(D2, 16'hFFFF, 1'b0, w);
    send(D3, 16'h00FF, 1'b1, w);
    idle(4);
    chk("match_count", cap.size(), 128'd3);
    chk_beat("match_b0", 0, D1, 16'hFFFF, 1'b0);
    chk_beat("match_b1", 1, D2, 16'hFFFF, 1'b0);
    chk_beat("match_b2", 2, D3, 16'h00FF, 1'b1);
    chk("match_opcode", {120'b0, rx_opcode}, 128'h21);
    chk("match_len_err", len_err_cnt, 128'd0);

    // Wrong destination: 5 beats all accepted without wait, nothing forwarded
    cap.delete();
`ifdef RX_DROP_CNT_EN
    chk("drop_cnt_before", {96'b0, drop_cnt}, 128'd0);
`endif
    send(hdr(8'h07, 8'h33, 16'd64), 16'hFFFF, 1'b0, w);
    chk("drop_hdr_wait", w, 128'd0);
    send(D1, 16'hFFFF, 1'b0, w); chk("drop_b0_wait", w, 128'd0);
    send(D2, 16'hFFFF, 1'b0, w); chk("drop_b1_wait", w, 128'd0);
    send(D3, 16'hFFFF, 1'b0, w); chk("drop_b2_wait", w, 128'd0);
    send(D4, 16'hFFFF, 1'b1, w); chk("drop_b3_wait", w, 128'd0);
    idle(4);
    chk("drop_count", cap.size(), 128'd0);
    chk("drop_opcode_kept", {120'b0, rx_opcode}, 128'h21);
`ifdef RX_DROP_CNT_EN
    chk("drop_cnt_after", {96'b0, drop_cnt}, 128'd1);
`endif

    // Length mismatch: len 32, 48 bytes received
    cap.delete(); len_err_cnt = 0; len_err_on_last = 0;
    send(hdr(8'h05, 8'h44, 16'd32), 16'hFFFF, 1'b0, w);
    send(D2, 16'hFFFF, 1'b0, w);
    send(D3, 16'hFFFF, 1'b0, w);
    send(D4, 16'hFFFF, 1'b1, w);
    idle(4);
    chk("lenerr_count", cap.size(), 128'd3);
    chk_beat("lenerr_b2", 2, D4, 16'hFFFF, 1'b1);
    chk("lenerr_pulses", len_err_cnt, 128'd1);
    chk("lenerr_on_last", len_err_on_last, 128'd1);
    chk("lenerr_opcode", {120'b0, rx_opcode}, 128'h44);

    // Backpressure: sink ready cycles 1,0,0,1 during a 64-byte payload
    cap.delete(); len_err_cnt = 0;
    send(hdr(8'h05, 8'h5A, 16'd64), 16'hFFFF, 1'b0, w);
    bp_idx = 0; bp_en = 1'b1;
    send(D4, 16'hFFFF, 1'b0, w);
    send(D3, 16'hFFFF, 1'b0, w);
    send(D2, 16'hFFFF, 1'b0, w);
    send(D1, 16'hFFFF, 1'b1, w);
    idle(12);
    bp_en = 1'b0;
    idle(2);
    chk("bp_count", cap.size(), 128'd4);
    chk_beat("bp_b0", 0, D4, 16'hFFFF, 1'b0);
    chk_beat("bp_b1", 1, D3, 16'hFFFF, 1'b0);
    chk_beat("bp_b2", 2, D2, 16'hFFFF, 1'b0);
    chk_beat("bp_b3", 3, D1, 16'hFFFF, 1'b1);
    chk("bp_len_err", len_err_cnt, 128'd0);

    // Header-only packet immediately followed by a valid packet
    cap.delete(); len_err_cnt = 0;
    send(hdr(8'h05, 8'h77, 16'd0), 16'hFFFF, 1'b1, w);
    send(hdr(8'h05, 8'h88, 16'd32), 16'hFFFF, 1'b0, w);
    chk("b2b_hdr_wait", w, 128'd0);
    send(D1, 16'hFFFF, 1'b0, w);
    send(D2, 16'hFFFF, 1'b1, w);
    idle(4);
    chk("b2b_count", cap.size(), 128'd2);
    chk_beat("b2b_b0", 0, D1, 16'hFFFF, 1'b0);
    chk_beat("b2b_b1", 1, D2, 16'hFFFF, 1'b1);
    chk("b2b_opcode", {120'b0, rx_opcode}, 128'h88);
    chk("b2b_len_err", len_err_cnt, 128'd0);
`ifdef RX_DROP_CNT_EN
    chk("b2b_drop_cnt", {96'b0, drop_cnt}, 128'd2);
`endif

    // Reset asserted while payload beat 2 is presented
    cap.delete(); len_err_cnt = 0;
    send(hdr(8'h05, 8'h55, 16'd48), 16'hFFFF, 1'b0, w);
    send(D1, 16'hFFFF, 1'b0, w);
    in_data = D2;
    #1;
    reset = 1'b0;
    #1;
    chk("mrst_out_valid", {127'b0, out_valid}, 128'd0);
    chk("mrst_out_data", out_data, 128'd0);
    chk("mrst_opcode", {120'b0, rx_opcode}, 128'd0);
    chk("mrst_in_ready", {127'b0, in_ready}, 128'd0);
`ifdef RX_DROP_CNT_EN
    chk("mrst_drop_cnt", {96'b0, drop_cnt}, 128'd0);
`endif
    in_valid = 1'b0;
    @(posedge clock);
    #2;
    reset = 1'b1;
    cap.delete();
    send(hdr(8'h05, 8'h66, 16'd16), 16'hFFFF, 1'b0, w);
    send(D3, 16'hFFFF, 1'b1, w);
    idle(4);
    chk("mrst_count", cap.size(), 128'd1);
    chk_beat("mrst_b0", 0, D3, 16'hFFFF, 1'b1);
    chk("mrst_new_opcode", {120'b0, rx_opcode}, 128'h66);
    chk("mrst_len_err", len_err_cnt, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
